// File: rtl/vector_segment_memory.sv
// Scratch memory segment that serves scalar element accesses and LANES-wide
// vector accesses from one single-port element array. A vector access walks
// its lanes one element per cycle, with a per-lane mask and an element stride.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | ready high, waiting for req
// ACCESS | one element per cycle; lane_q selects the lane, idx_q is its index
// DONE   | valid (and error, for a rejected request) high for one cycle
module vector_segment_memory #(
  parameter int LANES     = 4,
  parameter int LANE_W    = 16,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  output logic                    ready,
  input  logic                    write,
  input  logic                    vect,
  input  logic [63:0]             address,
  input  logic [7:0]              stride,
  input  logic [LANES-1:0]        lane_mask,
  input  logic [LANE_W-1:0]       data_in,
  input  logic [LANES*LANE_W-1:0] vect_in,
  output logic [LANE_W-1:0]       data_out,
  output logic [LANES*LANE_W-1:0] vect_out,
  output logic                    valid,
  output logic                    error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  // Headroom so that stepping past the last lane never wraps into a valid index.
  localparam int IW = AW + 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state;
  logic                    write_q;
  logic                    vect_q;
  logic [7:0]              stride_q;
  logic [LANES-1:0]        mask_q;
  logic [LANE_W-1:0]       data_q;
  logic [LANES*LANE_W-1:0] vdata_q;
  logic [IW-1:0]           idx_q;
  logic [CW-1:0]           lane_q;

  logic [LANE_W-1:0]       mem [DEPTH];

  logic [71:0]             addr_ext;
  logic [71:0]             base_ext;
  logic [71:0]             span;
  logic                    in_range;
  logic                    accept;
  logic                    lane_en;
  logic                    last_lane;
  logic                    mem_we;
  logic [LANE_W-1:0]       cur_wdata;
  logic [LANE_W-1:0]       cur_rdata;

  // Range check of the incoming request, done at full 72-bit width so that
  // large addresses or strides can never wrap into the window.
  always_comb begin
    addr_ext = {8'd0, address};
    base_ext = 72'(BASE_ADDR);
    span     = vect ? (72'(LANES - 1) * 72'(stride)) : 72'd0;
    in_range = (addr_ext >= base_ext) &&
               (((addr_ext - base_ext) + span) < 72'(DEPTH));
  end

  // Per-element controls for the lane currently being serviced.
  always_comb begin
    accept    = req && (state == IDLE);
    lane_en   = vect_q ? mask_q[lane_q] : 1'b1;
    last_lane = !vect_q || (lane_q == CW'(LANES - 1));
    cur_wdata = vect_q ? vdata_q[lane_q*LANE_W +: LANE_W] : data_q;
    cur_rdata = mem[idx_q[AW-1:0]];
    mem_we    = (state == ACCESS) && write_q && lane_en;
  end

  // Element array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q[AW-1:0]] <= cur_wdata;
  end

  // Sequencer: request capture, lane walk, read-data capture and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready    <= 1'b1;
      valid    <= 1'b0;
      error    <= 1'b0;
      data_out <= '0;
      vect_out <= '0;
      write_q  <= 1'b0;
      vect_q   <= 1'b0;
      stride_q <= '0;
      mask_q   <= '0;
      data_q   <= '0;
      vdata_q  <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          error <= 1'b0;
          if (accept) begin
            write_q  <= write;
            vect_q   <= vect;
            stride_q <= stride;
            mask_q   <= lane_mask;
            data_q   <= data_in;
            vdata_q  <= vect_in;
            idx_q    <= IW'(addr_ext - base_ext);
            lane_q   <= '0;
            ready    <= 1'b0;
            if (in_range) begin
              state <= ACCESS;
            end else begin
              state <= DONE;
              valid <= 1'b1;
              error <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (!write_q) begin
            if (vect_q) begin
              vect_out[lane_q*LANE_W +: LANE_W] <= lane_en ? cur_rdata : '0;
            end else begin
              data_out <= cur_rdata;
            end
          end
          idx_q  <= idx_q + IW'(stride_q);
          lane_q <= lane_q + CW'(1);
          if (last_lane) begin
            state <= DONE;
            valid <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          valid <= 1'b0;
          error <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          valid <= 1'b0;
          error <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_segment_memory.sv
// Directed bench for vector_segment_memory with default parameters.
module tb_vector_segment_memory;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        ready;
  logic        write;
  logic        vect;
  logic [63:0] address;
  logic [7:0]  stride;
  logic [3:0]  lane_mask;
  logic [15:0] data_in;
  logic [63:0] vect_in;
  logic [15:0] data_out;
  logic [63:0] vect_out;
  logic        valid;
  logic        error;

  int n_vec  = 0;
  int n_miss = 0;
  int lat;
  logic err;

  vector_segment_memory dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ready     (ready),
    .write     (write),
    .vect      (vect),
    .address   (address),
    .stride    (stride),
    .lane_mask (lane_mask),
    .data_in   (data_in),
    .vect_in   (vect_in),
    .data_out  (data_out),
    .vect_out  (vect_out),
    .valid     (valid),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One request. lat = edges after the accept edge until valid is seen.
  task automatic run_req(input logic w, input logic v, input logic [63:0] a,
                         input logic [7:0] s, input logic [3:0] m,
                         input logic [15:0] d, input logic [63:0] vi,
                         output int l, output logic e);
    int n;
    @(negedge clk);
    req = 1'b1; write = w; vect = v; address = a; stride = s;
    lane_mask = m; data_in = d; vect_in = vi;
    @(posedge clk);
    #1;
    req = 1'b0; write = 1'b0; vect = 1'b0; address = '0; stride = '0;
    lane_mask = '0; data_in = '0; vect_in = '0;
    chk_val("busy_after_accept", {63'd0, ready}, 64'd0);
    n = 0;
    while (!valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) chk_val("valid_timeout", 64'(n), 64'd0);
    l = n;
    e = error;
    @(posedge clk);
    #1;
    chk_val("valid_single", {63'd0, valid}, 64'd0);
    chk_val("ready_back", {63'd0, ready}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b1; write = 1'b1; vect = 1'b1; address = 64'd512;
    stride = 8'd1; lane_mask = 4'hF; data_in = 16'hFFFF; vect_in = '1;

    // Reset holds everything quiet even with req asserted.
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_ready", {63'd0, ready}, 64'd1);
    chk_val("rst_valid", {63'd0, valid}, 64'd0);
    chk_val("rst_error", {63'd0, error}, 64'd0);
    chk_val("rst_data_out", {48'd0, data_out}, 64'd0);
    chk_val("rst_vect_out", vect_out, 64'd0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Vector round trip.
    run_req(1, 1, 512, 1, 4'hF, 0, 64'hAAAA_BBBB_CCCC_DDDD, lat, err);
    chk_val("vwr_lat", 64'(lat), 64'd4);
    chk_val("vwr_err", {63'd0, err}, 64'd0);
    chk_val("vwr_vect_out", vect_out, 64'd0);
    run_req(0, 1, 512, 1, 4'hF, 0, 0, lat, err);
    chk_val("vrd_lat", 64'(lat), 64'd4);
    chk_val("vrd_data", vect_out, 64'hAAAA_BBBB_CCCC_DDDD);

    // Masked strided write touches 512 and 516 only.
    run_req(1, 1, 512, 2, 4'b0101, 0, 64'h4444_3333_2222_1111, lat, err);
    run_req(0, 1, 512, 1, 4'hF, 0, 0, lat, err);
    chk_val("mask_rd_full", vect_out, 64'hAAAA_BBBB_CCCC_1111);
    run_req(0, 1, 512, 1, 4'b0011, 0, 0, lat, err);
    chk_val("mask_rd_0011", vect_out, 64'h0000_0000_CCCC_1111);
    run_req(0, 1, 516, 1, 4'b0001, 0, 0, lat, err);
    chk_val("stride2_lane2", vect_out, 64'h0000_0000_0000_3333);
    run_req(0, 1, 512, 1, 4'b0011, 0, 0, lat, err);

    // Scalar / vector mix.
    run_req(1, 0, 515, 0, 4'h0, 16'h1234, 0, lat, err);
    chk_val("swr_lat", 64'(lat), 64'd1);
    run_req(0, 0, 515, 0, 4'h0, 0, 0, lat, err);
    chk_val("srd_lat", 64'(lat), 64'd1);
    chk_val("srd_data", {48'd0, data_out}, 64'h1234);
    chk_val("srd_vect_keep", vect_out, 64'h0000_0000_CCCC_1111);
    run_req(0, 1, 512, 1, 4'hF, 0, 0, lat, err);
    chk_val("mix_vrd", vect_out, 64'h1234_BBBB_CCCC_1111);
    chk_val("mix_data_keep", {48'd0, data_out}, 64'h1234);

    // Range errors: below base, and one element past the top.
    run_req(1, 1, 511, 1, 4'hF, 0, 64'hEEEE_EEEE_EEEE_EEEE, lat, err);
    chk_val("err_low_lat", 64'(lat), 64'd0);
    chk_val("err_low_flag", {63'd0, err}, 64'd1);
    run_req(1, 1, 512 + 1024 - 3, 1, 4'hF, 0, 64'hEEEE_EEEE_EEEE_EEEE, lat, err);
    chk_val("err_high_lat", 64'(lat), 64'd0);
    chk_val("err_high_flag", {63'd0, err}, 64'd1);
    chk_val("err_vect_keep", vect_out, 64'h1234_BBBB_CCCC_1111);
    run_req(1, 1, 512 + 1024 - 4, 1, 4'hF, 0, 64'h0004_0003_0002_0001, lat, err);
    chk_val("top_fit_err", {63'd0, err}, 64'd0);
    chk_val("top_fit_lat", 64'(lat), 64'd4);
    run_req(0, 0, 512 + 1023, 0, 4'h0, 0, 0, lat, err);
    chk_val("top_fit_rd", {48'd0, data_out}, 64'h0004);
    run_req(0, 1, 512, 1, 4'hF, 0, 0, lat, err);
    chk_val("err_mem_keep", vect_out, 64'h1234_BBBB_CCCC_1111);

    // Stride 0: highest unmasked lane wins.
    run_req(1, 1, 600, 0, 4'b0111, 0, 64'h0000_0003_0002_0001, lat, err);
    run_req(0, 0, 600, 0, 4'h0, 0, 0, lat, err);
    chk_val("stride0_rd", {48'd0, data_out}, 64'h0003);

    // Abort mid-access after two lanes have been written.
    run_req(1, 0, 702, 0, 4'h0, 16'h0BAD, 0, lat, err);
    run_req(1, 0, 703, 0, 4'h0, 16'h0BEE, 0, lat, err);
    @(negedge clk);
    req = 1'b1; write = 1'b1; vect = 1'b1; address = 700; stride = 1;
    lane_mask = 4'hF; vect_in = 64'h8888_7777_6666_5555;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_val("abort_ready", {63'd0, ready}, 64'd1);
    chk_val("abort_valid", {63'd0, valid}, 64'd0);
    @(posedge clk);
    #1;
    chk_val("abort_no_valid", {63'd0, valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(0, 0, 700, 0, 4'h0, 0, 0, lat, err);
    chk_val("abort_700", {48'd0, data_out}, 64'h5555);
    run_req(0, 0, 701, 0, 4'h0, 0, 0, lat, err);
    chk_val("abort_701", {48'd0, data_out}, 64'h6666);
    run_req(0, 0, 702, 0, 4'h0, 0, 0, lat, err);
    chk_val("abort_702", {48'd0, data_out}, 64'h0BAD);
    run_req(0, 0, 703, 0, 4'h0, 0, 0, lat, err);
    chk_val("abort_703", {48'd0, data_out}, 64'h0BEE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
